// File: rtl/intr_flag_ctrl.sv
// intr_flag_ctrl: interrupt sequencer for the MCU flag datapath.
// It synchronizes the external interrupt, owns the interrupt-enable bit, and
// enters the ISR through a request/acknowledge handshake with the control unit.
// It also strobes the Z/C shadow save on entry and the shadow restore on RETIE/RETID.
// Optional build macro INTR_FLAG_CTRL_STAT_EN adds a saturating serviced-interrupt
// counter on INT_CNT. Without the macro, INT_CNT is tied to zero.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | normal execution, waiting for an instruction boundary or RET*
// SAVE    | one cycle: copy Z/C into the shadow registers, request the vector
// VECT    | hold INT_REQ until the control unit acknowledges
// ISR     | servicing the interrupt; no nesting, waiting for RETIE/RETID
// RESTORE | one cycle: load Z/C from the shadow registers

module intr_flag_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INTR,
  input  logic             INSTR_END,
  input  logic             SEI,
  input  logic             CLI,
  input  logic             RETIE,
  input  logic             RETID,
  input  logic             INT_ACK,
  output logic             INT_REQ,
  output logic             FLG_SHAD_LD,
  output logic             FLG_LD_SEL,
  output logic             FLG_Z_LD_R,
  output logic             FLG_C_LD_R,
  output logic             IE,
  output logic             PEND,
  output logic             IN_ISR,
  output logic [CNT_W-1:0] INT_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_VECT,
    ST_ISR,
    ST_RESTORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   intr_rise;
  logic                   ret_req;
  logic                   enter_save;
  logic                   take_ret;

  assign intr_rise  = sync_q[SYNC_STAGES-1] & ~sync_d;
  assign ret_req    = RETIE | RETID;
  assign enter_save = (state == ST_IDLE) & ~ret_req & INSTR_END & PEND & IE;
  // RET* is honoured only where a return makes sense. In SAVE and VECT it is dropped.
  assign take_ret   = ((state == ST_IDLE) | (state == ST_ISR)) & ret_req;

  // INTR synchronizer chain, plus one extra flop for rising-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], INTR};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pending flag: taking the interrupt clears it.
  // An edge that coincides with entry merges into the interrupt being serviced.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PEND <= 1'b0;
    end else if (enter_save) begin
      PEND <= 1'b0;
    end else if (intr_rise) begin
      PEND <= 1'b1;
    end
  end

  // Interrupt enable: entry forces it off, RET* overrides SEI/CLI, and CLI beats SEI
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IE <= 1'b0;
    end else if (enter_save) begin
      IE <= 1'b0;
    end else if (take_ret) begin
      IE <= ~RETID;
    end else if (CLI) begin
      IE <= 1'b0;
    end else if (SEI) begin
      IE <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and strobes decoded purely from the current state
  always_comb begin
    state_nxt   = state;
    INT_REQ     = 1'b0;
    FLG_SHAD_LD = 1'b0;
    FLG_LD_SEL  = 1'b0;
    FLG_Z_LD_R  = 1'b0;
    FLG_C_LD_R  = 1'b0;
    IN_ISR      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ret_req) begin
          state_nxt = ST_RESTORE;
        end else if (enter_save) begin
          state_nxt = ST_SAVE;
        end
      end
      ST_SAVE: begin
        FLG_SHAD_LD = 1'b1;
        INT_REQ     = 1'b1;
        state_nxt   = ST_VECT;
      end
      ST_VECT: begin
        INT_REQ = 1'b1;
        if (INT_ACK) begin
          state_nxt = ST_ISR;
        end
      end
      ST_ISR: begin
        IN_ISR = 1'b1;
        if (ret_req) begin
          state_nxt = ST_RESTORE;
        end
      end
      ST_RESTORE: begin
        FLG_LD_SEL = 1'b1;
        FLG_Z_LD_R = 1'b1;
        FLG_C_LD_R = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef INTR_FLAG_CTRL_STAT_EN
  logic [CNT_W-1:0] cnt_q;

  // Serviced-interrupt counter: counts VECT->ISR transitions and saturates at all-ones
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if ((state == ST_VECT) && INT_ACK && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign INT_CNT = cnt_q;
`else
  assign INT_CNT = '0;
`endif

endmodule

// File: tb/tb_intr_flag_ctrl.sv
// Testbench for intr_flag_ctrl: directed scenarios plus a randomized run.
// All runs are checked against a behavioural model of the sequencer rules.
module tb_intr_flag_ctrl;

  localparam int SYNC = 2;
  localparam int CW   = 3;

  localparam int M_IDLE    = 0;
  localparam int M_SAVE    = 1;
  localparam int M_VECT    = 2;
  localparam int M_ISR     = 3;
  localparam int M_RESTORE = 4;

  logic          CLK = 1'b0;
  logic          RST_N, INTR, INSTR_END, SEI, CLI, RETIE, RETID, INT_ACK;
  logic          INT_REQ, FLG_SHAD_LD, FLG_LD_SEL, FLG_Z_LD_R, FLG_C_LD_R;
  logic          IE, PEND, IN_ISR;
  logic [CW-1:0] INT_CNT;

  int n_cmp = 0;
  int n_err = 0;

  int m_mode;
  bit m_pend, m_ie;
  int m_cnt;
  bit hist[$];

  intr_flag_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .INSTR_END(INSTR_END),
    .SEI(SEI), .CLI(CLI), .RETIE(RETIE), .RETID(RETID), .INT_ACK(INT_ACK),
    .INT_REQ(INT_REQ), .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_LD_SEL(FLG_LD_SEL),
    .FLG_Z_LD_R(FLG_Z_LD_R), .FLG_C_LD_R(FLG_C_LD_R), .IE(IE), .PEND(PEND),
    .IN_ISR(IN_ISR), .INT_CNT(INT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < SYNC + 1; i++) hist.push_back(1'b0);
    m_mode = M_IDLE;
    m_pend = 1'b0;
    m_ie   = 1'b0;
    m_cnt  = 0;
  endtask

  // hist[0] holds the most recently sampled INTR.
  // The synchronized level lags INTR by SYNC samples.
  task automatic model_step();
    bit rise, ret, go_save, go_ret;
    rise    = hist[SYNC-1] && !hist[SYNC];
    ret     = RETIE || RETID;
    go_save = (m_mode == M_IDLE) && !ret && INSTR_END && m_pend && m_ie;
    go_ret  = ((m_mode == M_IDLE) || (m_mode == M_ISR)) && ret;
    if (go_save) m_ie = 1'b0;
    else if (go_ret) m_ie = !RETID;
    else if (CLI) m_ie = 1'b0;
    else if (SEI) m_ie = 1'b1;
    if (go_save) m_pend = 1'b0;
    else if (rise) m_pend = 1'b1;
`ifdef INTR_FLAG_CTRL_STAT_EN
    if ((m_mode == M_VECT) && INT_ACK && (m_cnt < (1 << CW) - 1)) m_cnt++;
`endif
    case (m_mode)
      M_IDLE:  m_mode = ret ? M_RESTORE : (go_save ? M_SAVE : M_IDLE);
      M_SAVE:  m_mode = M_VECT;
      M_VECT:  m_mode = INT_ACK ? M_ISR : M_VECT;
      M_ISR:   m_mode = ret ? M_RESTORE : M_ISR;
      default: m_mode = M_IDLE;
    endcase
    hist.push_front(INTR);
    void'(hist.pop_back());
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_step();
    #1;
  endtask

  function automatic logic [7:0] dut_obs();
    return {INT_REQ, FLG_SHAD_LD, FLG_LD_SEL, FLG_Z_LD_R, FLG_C_LD_R, IE, PEND, IN_ISR};
  endfunction

  function automatic logic [7:0] exp_obs();
    bit restore;
    restore = (m_mode == M_RESTORE);
    return {(m_mode == M_SAVE) || (m_mode == M_VECT), m_mode == M_SAVE,
            restore, restore, restore, m_ie, m_pend, m_mode == M_ISR};
  endfunction

  task automatic clear_inputs();
    INSTR_END = 0; SEI = 0; CLI = 0; RETIE = 0; RETID = 0; INT_ACK = 0;
  endtask

  task automatic do_reset();
    RST_N = 0; INTR = 0; clear_inputs();
    tick(); tick();
    RST_N = 1;
  endtask

  task automatic enter_isr();
    INTR = 0; tick(); tick();
    INTR = 1; repeat (4) tick();
    INSTR_END = 1; tick(); INSTR_END = 0;
    tick(); tick();
    INT_ACK = 1; tick(); INT_ACK = 0;
  endtask

  task automatic test_reset();
    RST_N = 0; INTR = 1; clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut_obs() !== 8'h00 || INT_CNT !== '0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got obs=%b cnt=%0d, want obs=00000000 cnt=0", i, dut_obs(), INT_CNT);
      end
    end
    RST_N = 1;
    for (int i = 0; i < 8; i++) begin
      INSTR_END = i[0];
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs() || INT_REQ !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release[%0d]: got obs=%b, want %b", i, dut_obs(), exp_obs());
      end
    end
    clear_inputs(); INTR = 0;
  endtask

  task automatic test_basic_entry();
    do_reset();
    SEI = 1; tick(); SEI = 0;
    INTR = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs() || PEND !== (i == 3)) begin
        n_err++;
        $display("FAIL pend_latency[%0d]: got obs=%b pend=%b, want obs=%b pend=%b", i, dut_obs(), PEND, exp_obs(), i == 3);
      end
    end
    INSTR_END = 1; tick(); INSTR_END = 0;
    n_cmp++;
    if (dut_obs() !== exp_obs() || {FLG_SHAD_LD, INT_REQ, IE, PEND} !== 4'b1100) begin
      n_err++;
      $display("FAIL save_entry: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs() || INT_REQ !== 1'b1) begin
        n_err++;
        $display("FAIL vect_hold[%0d]: got obs=%b, want %b", i, dut_obs(), exp_obs());
      end
    end
    INT_ACK = 1; tick(); INT_ACK = 0;
    n_cmp++;
    if (dut_obs() !== exp_obs() || IN_ISR !== 1'b1 || INT_CNT !== m_cnt[CW-1:0]) begin
      n_err++;
      $display("FAIL isr_entry: got obs=%b cnt=%0d, want obs=%b cnt=%0d", dut_obs(), INT_CNT, exp_obs(), m_cnt);
    end
`ifdef INTR_FLAG_CTRL_STAT_EN
    n_cmp++;
    if (INT_CNT !== 3'd1) begin
      n_err++;
      $display("FAIL cnt_first: got %0d, want 1", INT_CNT);
    end
`endif
    INTR = 0;
  endtask

  task automatic test_restore();
    RETIE = 1; tick(); RETIE = 0;
    n_cmp++;
    if (dut_obs() !== exp_obs() || {FLG_LD_SEL, FLG_Z_LD_R, FLG_C_LD_R} !== 3'b111) begin
      n_err++;
      $display("FAIL retie_restore: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    tick();
    n_cmp++;
    if (dut_obs() !== exp_obs() || {FLG_LD_SEL, FLG_Z_LD_R, FLG_C_LD_R, IE} !== 4'b0001) begin
      n_err++;
      $display("FAIL retie_after: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    enter_isr();
    RETID = 1; tick(); RETID = 0;
    n_cmp++;
    if (dut_obs() !== exp_obs() || {FLG_LD_SEL, FLG_Z_LD_R, FLG_C_LD_R} !== 3'b111) begin
      n_err++;
      $display("FAIL retid_restore: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    tick();
    n_cmp++;
    if (dut_obs() !== exp_obs() || IE !== 1'b0 || FLG_LD_SEL !== 1'b0) begin
      n_err++;
      $display("FAIL retid_after: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    INTR = 0;
  endtask

  task automatic test_no_nesting();
    do_reset();
    SEI = 1; tick(); SEI = 0;
    enter_isr();
    INTR = 0; tick(); tick();
    INTR = 1;
    for (int i = 0; i < 6; i++) begin
      INSTR_END = 1'b1;
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs() || INT_REQ !== 1'b0 || IN_ISR !== 1'b1) begin
        n_err++;
        $display("FAIL nest_block[%0d]: got obs=%b, want %b", i, dut_obs(), exp_obs());
      end
    end
    INSTR_END = 0;
    SEI = 1; tick(); SEI = 0;
    n_cmp++;
    if (PEND !== 1'b1 || dut_obs() !== exp_obs()) begin
      n_err++;
      $display("FAIL nest_pend: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    RETIE = 1; tick(); RETIE = 0;
    tick();
    n_cmp++;
    if (dut_obs() !== exp_obs() || {IE, PEND, INT_REQ} !== 3'b110) begin
      n_err++;
      $display("FAIL nest_return: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    INSTR_END = 1; tick(); INSTR_END = 0;
    n_cmp++;
    if (dut_obs() !== exp_obs() || FLG_SHAD_LD !== 1'b1) begin
      n_err++;
      $display("FAIL nest_reentry: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    tick(); INT_ACK = 1; tick(); INT_ACK = 0;
    RETID = 1; tick(); RETID = 0; tick();
    n_cmp++;
    if (dut_obs() !== exp_obs() || INT_CNT !== m_cnt[CW-1:0]) begin
      n_err++;
      $display("FAIL nest_exit: got obs=%b cnt=%0d, want obs=%b cnt=%0d", dut_obs(), INT_CNT, exp_obs(), m_cnt);
    end
    INTR = 0;
  endtask

  task automatic test_priority();
    do_reset();
    SEI = 1; tick(); SEI = 0;
    INTR = 1; repeat (4) tick();
    n_cmp++;
    if ({PEND, IE} !== 2'b11 || dut_obs() !== exp_obs()) begin
      n_err++;
      $display("FAIL prio_setup: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    RETID = 1; INSTR_END = 1; tick(); RETID = 0; INSTR_END = 0;
    n_cmp++;
    if (dut_obs() !== exp_obs() || {FLG_LD_SEL, FLG_SHAD_LD, INT_REQ} !== 3'b100) begin
      n_err++;
      $display("FAIL prio_ret_wins: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    tick();
    n_cmp++;
    if (dut_obs() !== exp_obs() || {IE, PEND} !== 2'b01) begin
      n_err++;
      $display("FAIL prio_after: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    SEI = 1; tick();
    CLI = 1; tick(); SEI = 0; CLI = 0;
    n_cmp++;
    if (dut_obs() !== exp_obs() || IE !== 1'b0) begin
      n_err++;
      $display("FAIL sei_cli_both: got ie=%b, want 0", IE);
    end
    INTR = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    SEI = 1; tick(); SEI = 0;
    INTR = 1; repeat (4) tick();
    INSTR_END = 1; tick(); INSTR_END = 0;
    tick();
    n_cmp++;
    if (dut_obs() !== exp_obs() || INT_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL arst_in_vect: got obs=%b, want %b", dut_obs(), exp_obs());
    end
    #3 RST_N = 0;
    #1;
    n_cmp++;
    if (dut_obs() !== 8'h00 || INT_CNT !== '0) begin
      n_err++;
      $display("FAIL arst_immediate: got obs=%b cnt=%0d, want 00000000 cnt=0", dut_obs(), INT_CNT);
    end
    INTR = 0;
    tick(); tick();
    RST_N = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs() || {PEND, IE, INT_REQ} !== 3'b000 || INT_CNT !== '0) begin
        n_err++;
        $display("FAIL arst_release[%0d]: got obs=%b cnt=%0d, want %b cnt=0", i, dut_obs(), INT_CNT, exp_obs());
      end
    end
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      clear_inputs();
      if ($urandom_range(0, 7) == 0) INTR = ~INTR;
      INSTR_END = ($urandom_range(0, 2) == 0);
      INT_ACK   = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 15);
      case (op)
        0: SEI = 1;
        1: CLI = 1;
        2: RETIE = 1;
        3: RETID = 1;
        4: begin SEI = 1; CLI = 1; end
        5, 6: SEI = 1;
        default: ;
      endcase
      tick();
      n_cmp++;
      if (dut_obs() !== exp_obs() || INT_CNT !== m_cnt[CW-1:0]) begin
        n_err++;
        $display("FAIL random[%0d]: got obs=%b cnt=%0d, want obs=%b cnt=%0d", i, dut_obs(), INT_CNT, exp_obs(), m_cnt);
      end
    end
    clear_inputs(); INTR = 0;
  endtask

  initial begin
    RST_N = 0; INTR = 0; clear_inputs();
    model_reset();
    test_reset();
    test_basic_entry();
    test_restore();
    test_no_nesting();
    test_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
